// File: rtl/sr04_pkg.sv
// Shared definitions for the HC-SR04 link: state encoding, timing constants
// and the echo-width rule used by both the sensor emulator and the controller.
package sr04_pkg;

  localparam int CNT_W      = 16;
  localparam int US_PER_CM  = 58;
  localparam int TIMEOUT_US = 38000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // Zero or out-of-range distances report the sensor's no-echo timeout width.
  function automatic logic [CNT_W-1:0] echoWidth(input logic [9:0] distCm,
                                                 input int maxCm,
                                                 input int usPerCm,
                                                 input int timeoutUs);
    logic [CNT_W-1:0] prod;
    prod = CNT_W'(distCm) * CNT_W'(usPerCm);
    if (distCm == '0 || int'(distCm) > maxCm) echoWidth = CNT_W'(timeoutUs);
    else echoWidth = prod;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit (or independent) inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      meta <= '0;
      oQ   <= '0;
    end else begin
      meta <= iD;
      oQ   <= meta;
    end
  end

endmodule

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 sensor-side model: validates trigger width, waits the burst delay,
// then drives an echo whose width encodes the programmed distance.
module sr04_echo_emulator #(
  parameter int TRIG_MIN_TICKS = 9,
  parameter int BURST_US       = 200,
  parameter int US_PER_CM      = sr04_pkg::US_PER_CM,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_US     = sr04_pkg::TIMEOUT_US,
  parameter int HOLDOFF_US     = 10000
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iTickUs,
  input  logic       iTrig,
  input  logic [9:0] iDistanceCm,
  output logic       oEcho,
  output logic       oBusy,
  output logic       oTrigErr,
  output logic       oTrigIgnored,
  output logic       oMeasDone
);

  import sr04_pkg::*;

  localparam logic [CNT_W-1:0] TRIG_MIN   = CNT_W'(TRIG_MIN_TICKS);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_US - 1);

  state_e           state;
  logic             wTrigS, trigPrev, trigRise, trigFall;
  logic [CNT_W-1:0] cnt, cntTrig, echoTicks;
  logic [9:0]       distLat;

  sync_2ff #(.WIDTH(1)) uSync (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iD    (iTrig),
    .oQ    (wTrigS)
  );

  assign trigRise = wTrigS & ~trigPrev;
  assign trigFall = ~wTrigS & trigPrev;
  // Trigger count includes a tick landing on the fall cycle; saturates at the minimum.
  assign cntTrig  = (iTickUs && cnt < TRIG_MIN) ? cnt + 1'b1 : cnt;
  assign oBusy    = (state == ST_BURST) || (state == ST_ECHO) || (state == ST_HOLDOFF);

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      echoTicks    <= '0;
      distLat      <= '0;
      trigPrev     <= 1'b0;
      oEcho        <= 1'b0;
      oTrigErr     <= 1'b0;
      oTrigIgnored <= 1'b0;
      oMeasDone    <= 1'b0;
    end else begin
      trigPrev     <= wTrigS;
      oTrigErr     <= 1'b0;
      oMeasDone    <= 1'b0;
      oTrigIgnored <= trigRise & oBusy;
      case (state)
        ST_IDLE: begin
          if (trigRise) begin
            cnt   <= '0;
            state <= ST_TRIG_HI;
          end
        end
        ST_TRIG_HI: begin
          cnt <= cntTrig;
          if (trigFall) begin
            cnt <= '0;
            if (cntTrig >= TRIG_MIN) begin
              distLat <= iDistanceCm;
              state   <= ST_BURST;
            end else begin
              oTrigErr <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_BURST: begin
          if (iTickUs) begin
            if (cnt == BURST_LAST) begin
              cnt       <= '0;
              echoTicks <= echoWidth(distLat, MAX_CM, US_PER_CM, TIMEOUT_US);
              oEcho     <= 1'b1;
              state     <= ST_ECHO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_ECHO: begin
          if (iTickUs) begin
            if (cnt == echoTicks - 1'b1) begin
              cnt       <= '0;
              oEcho     <= 1'b0;
              oMeasDone <= 1'b1;
              state     <= ST_HOLDOFF;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (iTickUs) begin
            if (cnt == HOLD_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
